// File: rtl/gemm_fp_pkg.sv
// Shared mini-float helpers for the GEMM datapath: lane widths,
// sign/magnitude conversion and exponent/mantissa saturation values.
package gemm_fp_pkg;

   // Width of one aligned lane: sign + hidden + stored bits + headroom + guards.
   function automatic int lane_w(input int sig_w, input int low_x);
      return sig_w + 4 + low_x;
   endfunction

   // Width of a two's-complement lane sum that cannot overflow for four lanes.
   function automatic int sum_w(input int sig_w, input int low_x);
      return lane_w(sig_w, low_x) + 2;
   endfunction

   // Largest encodable biased exponent (no inf/NaN codes are reserved).
   function automatic int exp_max(input int exp_w);
      return int'((32'd1 << exp_w) - 32'd1);
   endfunction

   // Largest stored mantissa, used when saturating.
   function automatic int man_max(input int sig_w);
      return int'((32'd1 << sig_w) - 32'd1);
   endfunction

   // Sign/magnitude to two's complement; a negative zero maps to plain zero.
   function automatic logic [31:0] sm_to_tc(input logic sgn, input logic [31:0] mag);
      logic [31:0] r;
      if (sgn && (mag != 32'd0)) begin
         r = ~mag + 32'd1;
      end else begin
         r = mag;
      end
      return r;
   endfunction

endpackage

// File: rtl/leading_one_pos.sv
// Combinational priority encoder: position of the most significant set bit.
module leading_one_pos #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         vec,
   output logic [$clog2(WIDTH)-1:0] pos,
   output logic                     found
);

   localparam int PW = $clog2(WIDTH);

   // Scan upward so the highest set bit is the last one to win.
   always_comb begin
      pos   = {PW{1'b0}};
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         pos   = vec[i] ? PW'(i) : pos;
         found = found | vec[i];
      end
   end

endmodule

// File: rtl/man_adder_norm.sv
// Four-lane aligned-mantissa adder with normalisation back to the mini-float
// format. Three register stages (pair sums, final sum/abs, normalise) with a
// valid/ready pipeline that collapses bubbles and holds results under stall.
module man_adder_norm
   import gemm_fp_pkg::*;
#(
   parameter int expWidth   = 3,
   parameter int sigWidth   = 3,
   parameter int low_expand = 2
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [4*lane_w(sigWidth, low_expand)-1:0] man_off,
   input  logic [expWidth-1:0]                       max_exp,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic                                      res_sign,
   output logic [expWidth-1:0]                       res_exp,
   output logic [sigWidth-1:0]                       res_man,
   output logic                                      res_ovf,
   output logic                                      res_unf
);

   localparam int W  = lane_w(sigWidth, low_expand);
   localparam int SW = sum_w(sigWidth, low_expand);
   localparam int MW = W + 1;
   localparam int H  = sigWidth + low_expand;
   localparam int EW = expWidth + 3;
   localparam int PW = $clog2(MW);

   localparam logic [EW-1:0]       EMAX    = EW'(exp_max(expWidth));
   localparam logic [EW-1:0]       HIDDEN  = EW'(H);
   localparam logic [expWidth-1:0] EXP_SAT = expWidth'(exp_max(expWidth));
   localparam logic [sigWidth-1:0] MAN_SAT = sigWidth'(man_max(sigWidth));

   logic                v1, v2, v3;
   logic                en1, en2, en3;
   logic [SW-1:0]       tc [4];
   logic [SW-1:0]       p01, p23;
   logic [expWidth-1:0] exp1, exp2;
   logic [SW-1:0]       sum;
   logic [MW-1:0]       mag_c;
   logic                sign2, zero2;
   logic [MW-1:0]       mag2;
   logic [PW-1:0]       pos, sh;
   logic                found;
   logic                is_zero;
   logic [EW-1:0]       e_val;
   logic [MW-1:0]       norm;
   logic [sigWidth-1:0] man_c;
   logic                n_sign, n_ovf, n_unf;
   logic [expWidth-1:0] n_exp;
   logic [sigWidth-1:0] n_man;

   // A stage advances when it is empty or the next stage takes its contents.
   assign en3       = !v3 | out_ready;
   assign en2       = !v2 | en3;
   assign en1       = !v1 | en2;
   assign in_ready  = en1;
   assign out_valid = v3;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign tc[i] = SW'(sm_to_tc(man_off[W*i+W-1], 32'(man_off[W*i +: W-1])));
   end

   // Stage valid bits; reset discards everything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (en1) v1 <= in_valid;
         if (en2) v2 <= v1;
         if (en3) v3 <= v2;
      end
   end

   // S1: register the two pair sums and the shared exponent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p01  <= {SW{1'b0}};
         p23  <= {SW{1'b0}};
         exp1 <= {expWidth{1'b0}};
      end else if (en1 && in_valid) begin
         p01  <= tc[0] + tc[1];
         p23  <= tc[2] + tc[3];
         exp1 <= max_exp;
      end
   end

   assign sum   = p01 + p23;
   assign mag_c = MW'(sum[SW-1] ? (~sum + SW'(1'b1)) : sum);

   // S2: register sign, magnitude and zero flag of the full sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign2 <= 1'b0;
         zero2 <= 1'b0;
         mag2  <= {MW{1'b0}};
         exp2  <= {expWidth{1'b0}};
      end else if (en2 && v1) begin
         sign2 <= sum[SW-1];
         zero2 <= (sum == {SW{1'b0}});
         mag2  <= mag_c;
         exp2  <= exp1;
      end
   end

   leading_one_pos #(
      .WIDTH (MW)
   ) u_lop (
      .vec   (mag2),
      .pos   (pos),
      .found (found)
   );

   // Exponent wraps modulo 2^EW, so its top bit acts as the sign.
   assign e_val   = EW'(exp2) + EW'(pos) - HIDDEN;
   assign sh      = PW'(MW-1) - pos;
   assign norm    = mag2 << sh;
   assign man_c   = sigWidth'(norm >> (MW - 1 - sigWidth));
   assign is_zero = zero2 | !found;

   // S3 result selection: zero, flush, saturate, or normal, in that priority.
   always_comb begin
      n_sign = 1'b0;
      n_exp  = {expWidth{1'b0}};
      n_man  = {sigWidth{1'b0}};
      n_ovf  = 1'b0;
      n_unf  = 1'b0;
      if (is_zero) begin
         n_unf = 1'b0;
      end else if (e_val[EW-1] || (e_val == {EW{1'b0}})) begin
         n_unf = 1'b1;
      end else if (e_val > EMAX) begin
         n_sign = sign2;
         n_exp  = EXP_SAT;
         n_man  = MAN_SAT;
         n_ovf  = 1'b1;
      end else begin
         n_sign = sign2;
         n_exp  = expWidth'(e_val);
         n_man  = man_c;
      end
   end

   // S3: output registers, held while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_sign <= 1'b0;
         res_exp  <= {expWidth{1'b0}};
         res_man  <= {sigWidth{1'b0}};
         res_ovf  <= 1'b0;
         res_unf  <= 1'b0;
      end else if (en3 && v2) begin
         res_sign <= n_sign;
         res_exp  <= n_exp;
         res_man  <= n_man;
         res_ovf  <= n_ovf;
         res_unf  <= n_unf;
      end
   end

endmodule

// File: tb/tb_man_adder_norm.sv
// Directed bench for man_adder_norm with default parameters (W=9, H=5).
module tb_man_adder_norm;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [35:0] man_off;
   logic [2:0]  max_exp;
   logic        out_valid;
   logic        out_ready;
   logic        res_sign;
   logic [2:0]  res_exp;
   logic [2:0]  res_man;
   logic        res_ovf;
   logic        res_unf;

   int vectors     = 0;
   int miscompares = 0;

   logic [35:0] s_lanes [6];
   logic [2:0]  s_exp   [6];
   logic [8:0]  s_res   [6];

   man_adder_norm dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .man_off   (man_off),
      .max_exp   (max_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_sign  (res_sign),
      .res_exp   (res_exp),
      .res_man   (res_man),
      .res_ovf   (res_ovf),
      .res_unf   (res_unf)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [8:0] pk(input logic s, input logic [2:0] e, input logic [2:0] m,
                                     input logic o, input logic u);
      return {s, e, m, o, u};
   endfunction

   function automatic logic [8:0] res_now();
      return {res_sign, res_exp, res_man, res_ovf, res_unf};
   endfunction

   function automatic logic [35:0] lanes(input logic [8:0] l0, input logic [8:0] l1,
                                         input logic [8:0] l2, input logic [8:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // One beat through an otherwise empty pipeline, checking latency 3.
   task automatic single(input string tag, input logic [35:0] lv, input logic [2:0] me,
                         input logic [8:0] expv);
      in_valid = 1'b1;
      man_off  = lv;
      max_exp  = me;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      tick;
      in_valid = 1'b0;
      man_off  = 36'd0;
      tick;
      chk({tag, "_early"}, out_valid, 0);
      tick;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_res"}, res_now(), expv);
      tick;
   endtask

   // Stream the six table beats; out_ready is held low for the first 'stall' cycles.
   task automatic stream(input string tag, input int stall, output int cycles);
      int   ni  = 0;
      int   no  = 0;
      int   cyc = 0;
      logic acc;
      while ((ni < 6 || no < 6) && cyc < 60) begin
         out_ready = (cyc >= stall);
         in_valid  = (ni < 6);
         man_off   = (ni < 6) ? s_lanes[ni] : 36'd0;
         max_exp   = (ni < 6) ? s_exp[ni] : 3'd0;
         #1;
         if (stall > 0 && cyc == 3) begin
            chk({tag, "_ready_drop"}, in_ready, 0);
            chk({tag, "_accepts"}, ni, 3);
         end
         if (stall == 0 && ni < 6) chk({tag, "_ready_high"}, in_ready, 1);
         if (out_valid) begin
            chk({tag, "_res"}, res_now(), s_res[no]);
            if (out_ready) no++;
         end
         acc = in_valid & in_ready;
         tick;
         if (acc) ni++;
         cyc++;
      end
      in_valid = 1'b0;
      chk({tag, "_done"}, (ni == 6) && (no == 6), 1);
      cycles = cyc;
   endtask

   initial begin
      int cycles;

      s_lanes[0] = lanes(9'h020, 9'h020, 9'h020, 9'h020); s_exp[0] = 3'd3; s_res[0] = pk(1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
      s_lanes[1] = lanes(9'h130, 9'h130, 9'h130, 9'h130); s_exp[1] = 3'd2; s_res[1] = pk(1'b1, 3'd4, 3'd4, 1'b0, 1'b0);
      s_lanes[2] = lanes(9'h020, 9'h000, 9'h000, 9'h000); s_exp[2] = 3'd4; s_res[2] = pk(1'b0, 3'd4, 3'd0, 1'b0, 1'b0);
      s_lanes[3] = lanes(9'h03F, 9'h000, 9'h000, 9'h000); s_exp[3] = 3'd5; s_res[3] = pk(1'b0, 3'd5, 3'd7, 1'b0, 1'b0);
      s_lanes[4] = lanes(9'h020, 9'h130, 9'h000, 9'h000); s_exp[4] = 3'd3; s_res[4] = pk(1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
      s_lanes[5] = lanes(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF); s_exp[5] = 3'd2; s_res[5] = pk(1'b0, 3'd6, 3'd7, 1'b0, 1'b0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      man_off   = 36'd0;
      max_exp   = 3'd0;
      tick;
      tick;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_res", res_now(), 0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);

      single("one_x4",     lanes(9'h020, 9'h020, 9'h020, 9'h020), 3'd3, pk(1'b0, 3'd5, 3'd0, 1'b0, 1'b0));
      single("m1p5_x4",    lanes(9'h130, 9'h130, 9'h130, 9'h130), 3'd2, pk(1'b1, 3'd4, 3'd4, 1'b0, 1'b0));
      single("cancel",     lanes(9'h020, 9'h120, 9'h020, 9'h120), 3'd5, pk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
      single("ovf_pos",    lanes(9'h020, 9'h020, 9'h020, 9'h020), 3'd6, pk(1'b0, 3'd7, 3'd7, 1'b1, 1'b0));
      single("unf_tiny",   lanes(9'h001, 9'h000, 9'h000, 9'h000), 3'd3, pk(1'b0, 3'd0, 3'd0, 1'b0, 1'b1));
      single("neg_zero",   lanes(9'h100, 9'h100, 9'h100, 9'h100), 3'd7, pk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0));
      single("ovf_neg",    lanes(9'h130, 9'h130, 9'h130, 9'h130), 3'd6, pk(1'b1, 3'd7, 3'd7, 1'b1, 1'b0));
      single("exp_top",    lanes(9'h020, 9'h020, 9'h020, 9'h020), 3'd5, pk(1'b0, 3'd7, 3'd0, 1'b0, 1'b0));
      single("exp_one",    lanes(9'h020, 9'h000, 9'h000, 9'h000), 3'd1, pk(1'b0, 3'd1, 3'd0, 1'b0, 1'b0));
      single("exp_zero",   lanes(9'h020, 9'h000, 9'h000, 9'h000), 3'd0, pk(1'b0, 3'd0, 3'd0, 1'b0, 1'b1));
      single("max_mag",    lanes(9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF), 3'd1, pk(1'b0, 3'd5, 3'd7, 1'b0, 1'b0));
      single("zero_fill",  lanes(9'h107, 9'h001, 9'h000, 9'h000), 3'd7, pk(1'b1, 3'd4, 3'd4, 1'b0, 1'b0));

      stream("bp", 5, cycles);
      chk("bp_cycles", cycles, 11);
      stream("full", 0, cycles);
      chk("full_cycles", cycles, 9);

      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         man_off  = s_lanes[k];
         max_exp  = s_exp[k];
         tick;
      end
      in_valid = 1'b0;
      man_off  = 36'd0;
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_res", res_now(), 0);
      tick;
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      for (int k = 0; k < 5; k++) begin
         chk("rst_no_stale", out_valid, 0);
         tick;
      end
      single("post_rst", s_lanes[1], s_exp[1], s_res[1]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
